vec_src_arbiter: RTL and testbench

- Shares the single upstream vector-stream port of the vector concatenation stage between two DMA-fed sources.
- Sources: source 0 carries the reference batch, source 1 carries the compare batch.
- Arbitrates at batch granularity: once granted, a source owns the port until its Last beat is accepted. Round-robin between batches.
- Provides a per-batch beat counter, per-source batch counters and a sticky overrun flag for the host.

---
 rtl/vec_src_arbiter.sv | 134 +++++++++++++
 tb/tb_vec_src_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_src_arbiter.sv
// Purpose : batch-granular round-robin arbiter sharing one vector-stream port
//           between source 0 (reference batch) and source 1 (compare batch).
// Latency : data path is combinational pass-through while busy; one IDLE
//           bubble cycle per batch for arbitration.
// Backpressure: dn_Ready is forwarded to the owning source only; when it is
//           low, state and counters hold and data stalls at the source.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   s0_Vector/Valid/Last, s0_Ready    source 0 stream
//   s1_Vector/Valid/Last, s1_Ready    source 1 stream
//   dn_Vector/Valid/Last, dn_Ready    shared downstream stream
//   grant_Src, busy                   current owner / batch in progress
//   batch_Cnt0, batch_Cnt1            completed batches per source (wrap)
//   beat_Cnt                          beats accepted in current batch (sat)
//   overrun                           sticky: batch hit MAX_BEATS without Last
module vec_src_arbiter #(
  parameter int BUS_WIDTH = 128,
  parameter int CNT_WIDTH = 16,
  parameter int MAX_BEATS = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] s0_Vector,
  input  logic                 s0_Valid,
  input  logic                 s0_Last,
  output logic                 s0_Ready,
  input  logic [BUS_WIDTH-1:0] s1_Vector,
  input  logic                 s1_Valid,
  input  logic                 s1_Last,
  output logic                 s1_Ready,
  output logic [BUS_WIDTH-1:0] dn_Vector,
  output logic                 dn_Valid,
  output logic                 dn_Last,
  input  logic                 dn_Ready,
  output logic                 grant_Src,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] batch_Cnt0,
  output logic [CNT_WIDTH-1:0] batch_Cnt1,
  output logic [CNT_WIDTH-1:0] beat_Cnt,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  // Beat count value whose increment lands exactly on MAX_BEATS.
  localparam logic [CNT_WIDTH-1:0] MAX_M1 = CNT_WIDTH'(MAX_BEATS - 1);

  state_t               r_state;
  logic                 r_last_srv;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_batch_cnt0;
  logic [CNT_WIDTH-1:0] r_batch_cnt1;
  logic                 r_overrun;

  logic w_busy;
  logic w_sel;
  logic w_src_vld;
  logic w_src_last;
  logic w_beat;

  assign w_busy     = (r_state != IDLE);
  assign w_sel      = (r_state == BUSY1);
  assign w_src_vld  = w_sel ? s1_Valid : s0_Valid;
  assign w_src_last = w_sel ? s1_Last  : s0_Last;
  assign w_beat     = w_busy && w_src_vld && dn_Ready;

  // Pass-through mux; everything is forced low in IDLE so nothing leaks
  // downstream between batches or right after reset.
  assign dn_Vector = (r_state == BUSY0) ? s0_Vector :
                     (r_state == BUSY1) ? s1_Vector : '0;
  assign dn_Valid  = w_busy && w_src_vld;
  assign dn_Last   = w_busy && w_src_last;
  assign s0_Ready  = (r_state == BUSY0) && dn_Ready;
  assign s1_Ready  = (r_state == BUSY1) && dn_Ready;

  assign busy       = w_busy;
  assign grant_Src  = w_sel;
  assign batch_Cnt0 = r_batch_cnt0;
  assign batch_Cnt1 = r_batch_cnt1;
  assign beat_Cnt   = r_beat_cnt;
  assign overrun    = r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_srv   <= 1'b1;  // makes source 0 win the first tie
      r_beat_cnt   <= '0;
      r_batch_cnt0 <= '0;
      r_batch_cnt1 <= '0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat_cnt <= '0;
          // On a tie, grant the source that was not served last.
          if (s0_Valid && (!s1_Valid || r_last_srv)) begin
            r_state <= BUSY0;
          end else if (s1_Valid) begin
            r_state <= BUSY1;
          end
        end
        BUSY0, BUSY1: begin
          if (w_beat) begin
            if (w_src_last) begin
              r_state    <= IDLE;
              r_last_srv <= w_sel;
              r_beat_cnt <= '0;
              if (w_sel) begin
                r_batch_cnt1 <= r_batch_cnt1 + CNT_WIDTH'(1);
              end else begin
                r_batch_cnt0 <= r_batch_cnt0 + CNT_WIDTH'(1);
              end
            end else begin
              if (r_beat_cnt != '1) begin
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
              end
              // This non-last beat brings the count to MAX_BEATS.
              if (r_beat_cnt == MAX_M1) begin
                r_overrun <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_src_arbiter.sv
module tb_vec_src_arbiter;

  localparam int BW = 32;
  localparam int CW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] s0_Vector, s1_Vector, dn_Vector;
  logic          s0_Valid, s0_Last, s0_Ready;
  logic          s1_Valid, s1_Last, s1_Ready;
  logic          dn_Valid, dn_Last, dn_Ready;
  logic          grant_Src, busy, overrun;
  logic [CW-1:0] batch_Cnt0, batch_Cnt1, beat_Cnt;

  int checks = 0;
  int failures = 0;

  vec_src_arbiter #(.BUS_WIDTH(BW), .CNT_WIDTH(CW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .s0_Vector(s0_Vector), .s0_Valid(s0_Valid), .s0_Last(s0_Last), .s0_Ready(s0_Ready),
    .s1_Vector(s1_Vector), .s1_Valid(s1_Valid), .s1_Last(s1_Last), .s1_Ready(s1_Ready),
    .dn_Vector(dn_Vector), .dn_Valid(dn_Valid), .dn_Last(dn_Last), .dn_Ready(dn_Ready),
    .grant_Src(grant_Src), .busy(busy),
    .batch_Cnt0(batch_Cnt0), .batch_Cnt1(batch_Cnt1),
    .beat_Cnt(beat_Cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] va(input int b, input int k);
    return BW'(32'hA000_0000 + b * 256 + k);
  endfunction

  function automatic logic [BW-1:0] vb(input int b, input int k);
    return BW'(32'hB000_0000 + b * 256 + k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs in the low phase; outputs settle before the next posedge.
  task automatic step(input logic [BW-1:0] v0, input logic vl0, input logic l0,
                      input logic [BW-1:0] v1, input logic vl1, input logic l1,
                      input logic rdy);
    @(negedge clk);
    s0_Vector = v0; s0_Valid = vl0; s0_Last = l0;
    s1_Vector = v1; s1_Valid = vl1; s1_Last = l1;
    dn_Ready  = rdy;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},     64'(busy), 64'd0);
    chk({tag, ".dn_Valid"}, 64'(dn_Valid), 64'd0);
    chk({tag, ".s0_Ready"}, 64'(s0_Ready), 64'd0);
    chk({tag, ".s1_Ready"}, 64'(s1_Ready), 64'd0);
    chk({tag, ".beat_Cnt"}, 64'(beat_Cnt), 64'd0);
  endtask

  task automatic chk_busy(input string tag, input logic g, input logic [BW-1:0] vec,
                          input logic vld, input logic last, input logic r0,
                          input logic r1, input int beat);
    chk({tag, ".busy"},      64'(busy), 64'd1);
    chk({tag, ".grant"},     64'(grant_Src), 64'(g));
    chk({tag, ".dn_Vector"}, 64'(dn_Vector), 64'(vec));
    chk({tag, ".dn_Valid"},  64'(dn_Valid), 64'(vld));
    chk({tag, ".dn_Last"},   64'(dn_Last), 64'(last));
    chk({tag, ".s0_Ready"},  64'(s0_Ready), 64'(r0));
    chk({tag, ".s1_Ready"},  64'(s1_Ready), 64'(r1));
    chk({tag, ".beat_Cnt"},  64'(beat_Cnt), 64'(beat));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_Vector = '0; s0_Valid = 1'b0; s0_Last = 1'b0;
    s1_Vector = '0; s1_Valid = 1'b0; s1_Last = 1'b0;
    dn_Ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("rst");
    chk("rst.grant",   64'(grant_Src), 64'd0);
    chk("rst.dn_Vec",  64'(dn_Vector), 64'd0);
    chk("rst.dn_Last", 64'(dn_Last), 64'd0);
    chk("rst.cnt0",    64'(batch_Cnt0), 64'd0);
    chk("rst.cnt1",    64'(batch_Cnt1), 64'd0);
    chk("rst.overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    // ---- A: both sources contend with 3-beat batches: grants 0,1,0,1
    do_reset();
    for (int b = 0; b < 4; b++) begin
      step(va(b, 0), 1'b1, 1'b0, vb(b, 0), 1'b1, 1'b0, 1'b1);
      chk_idle($sformatf("A.idle%0d", b));
      chk($sformatf("A.cnt0_%0d", b), 64'(batch_Cnt0), 64'((b + 1) / 2));
      chk($sformatf("A.cnt1_%0d", b), 64'(batch_Cnt1), 64'(b / 2));
      for (int k = 0; k < 3; k++) begin
        if (b % 2 == 0) begin
          step(va(b, k), 1'b1, k == 2, vb(b, 9), 1'b1, 1'b0, 1'b1);
          chk_busy($sformatf("A.b%0dk%0d", b, k), 1'b0, va(b, k), 1'b1, k == 2, 1'b1, 1'b0, k);
        end else begin
          step(va(b, 9), 1'b1, 1'b0, vb(b, k), 1'b1, k == 2, 1'b1);
          chk_busy($sformatf("A.b%0dk%0d", b, k), 1'b1, vb(b, k), 1'b1, k == 2, 1'b0, 1'b1, k);
        end
      end
    end
    step('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("A.end");
    chk("A.cnt0", 64'(batch_Cnt0), 64'd2);
    chk("A.cnt1", 64'(batch_Cnt1), 64'd2);

    // ---- B: source 0 alone, two 2-beat batches, no forced alternation
    do_reset();
    for (int b = 0; b < 2; b++) begin
      step(va(b, 0), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk_idle($sformatf("B.idle%0d", b));
      for (int k = 0; k < 2; k++) begin
        step(va(b, k), 1'b1, k == 1, '0, 1'b0, 1'b0, 1'b1);
        chk_busy($sformatf("B.b%0dk%0d", b, k), 1'b0, va(b, k), 1'b1, k == 1, 1'b1, 1'b0, k);
      end
    end
    step('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("B.end");
    chk("B.cnt0", 64'(batch_Cnt0), 64'd2);
    chk("B.cnt1", 64'(batch_Cnt1), 64'd0);

    // ---- C: source 1 requests during beat 2 of a 5-beat source 0 batch
    do_reset();
    step(va(0, 0), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("C.idle");
    for (int k = 0; k < 5; k++) begin
      step(va(0, k), 1'b1, k == 4, vb(0, 0), k >= 1, 1'b0, 1'b1);
      chk_busy($sformatf("C.k%0d", k), 1'b0, va(0, k), 1'b1, k == 4, 1'b1, 1'b0, k);
    end
    step('0, 1'b0, 1'b0, vb(0, 0), 1'b1, 1'b0, 1'b1);
    chk_idle("C.bubble");
    chk("C.cnt0", 64'(batch_Cnt0), 64'd1);
    step('0, 1'b0, 1'b0, vb(0, 0), 1'b1, 1'b0, 1'b1);
    chk_busy("C.g1", 1'b1, vb(0, 0), 1'b1, 1'b0, 1'b0, 1'b1, 0);

    // ---- D: dn_Ready 1,0,0,1 during a source 1 batch
    do_reset();
    step('0, 1'b0, 1'b0, vb(0, 0), 1'b1, 1'b0, 1'b1);
    chk_idle("D.idle");
    step('0, 1'b0, 1'b0, vb(0, 0), 1'b1, 1'b0, 1'b1);
    chk_busy("D.c0", 1'b1, vb(0, 0), 1'b1, 1'b0, 1'b0, 1'b1, 0);
    step('0, 1'b0, 1'b0, vb(0, 1), 1'b1, 1'b1, 1'b0);
    chk_busy("D.c1", 1'b1, vb(0, 1), 1'b1, 1'b1, 1'b0, 1'b0, 1);
    step('0, 1'b0, 1'b0, vb(0, 1), 1'b1, 1'b1, 1'b0);
    chk_busy("D.c2", 1'b1, vb(0, 1), 1'b1, 1'b1, 1'b0, 1'b0, 1);
    step('0, 1'b0, 1'b0, vb(0, 1), 1'b1, 1'b1, 1'b1);
    chk_busy("D.c3", 1'b1, vb(0, 1), 1'b1, 1'b1, 1'b0, 1'b1, 1);
    step('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("D.end");
    chk("D.cnt1", 64'(batch_Cnt1), 64'd1);

    // ---- E: MAX_BEATS=4, 6-beat batch -> overrun after beat 4, sticky
    do_reset();
    step(va(0, 0), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("E.idle");
    for (int k = 0; k < 6; k++) begin
      step(va(0, k), 1'b1, k == 5, '0, 1'b0, 1'b0, 1'b1);
      chk_busy($sformatf("E.k%0d", k), 1'b0, va(0, k), 1'b1, k == 5, 1'b1, 1'b0, k);
      chk($sformatf("E.ovr%0d", k), 64'(overrun), 64'(k >= 4));
    end
    step('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("E.end");
    chk("E.ovr_end", 64'(overrun), 64'd1);
    chk("E.cnt0", 64'(batch_Cnt0), 64'd1);

    // ---- F: reset during beat 3 of a source 0 batch (source 1 was favoured)
    step(va(1, 0), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_idle("F.idle");
    for (int k = 0; k < 3; k++) begin
      step(va(1, k), 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk_busy($sformatf("F.k%0d", k), 1'b0, va(1, k), 1'b1, 1'b0, 1'b1, 1'b0, k);
    end
    chk("F.pre_cnt0", 64'(batch_Cnt0), 64'd1);
    chk("F.pre_ovr",  64'(overrun), 64'd1);
    rst = 1'b1;
    #1;
    chk_idle("F.rst");
    chk("F.rst_cnt0", 64'(batch_Cnt0), 64'd0);
    chk("F.rst_ovr",  64'(overrun), 64'd0);
    step(va(2, 0), 1'b1, 1'b0, vb(2, 0), 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle("F.rel");
    step(va(2, 0), 1'b1, 1'b0, vb(2, 0), 1'b1, 1'b0, 1'b1);
    chk_busy("F.g0", 1'b0, va(2, 0), 1'b1, 1'b0, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
